// File: rtl/issue_scoreboard_pkg.sv
// Shared constants for the issue scoreboard: default sizing, register-index
// width and the index of the hard-wired zero register.
package issue_scoreboard_pkg;

  localparam int unsigned NREG_DEFAULT    = 32;
  localparam int unsigned CNT_W_DEFAULT   = 2;
  localparam int unsigned DIV_LAT_DEFAULT = 17;
  localparam int unsigned REG_W           = 5;

  localparam logic [REG_W-1:0] REG_ZERO = '0;

endpackage

// File: rtl/issue_scoreboard_if.sv
// Issue handshake between the dual-issue queue (master) and the scoreboard (slave).
//   reg_allowin          : register-read stage can accept this cycle
//   s0_* / s1_*          : per-slot valid, rd/rj/rk indices, long-latency and divide flags
//   issue_ok0/issue_ok1  : slot may issue (combinational grant)
//   fire0/fire1          : slot actually issued this cycle
interface issue_scoreboard_if;
  import issue_scoreboard_pkg::*;

  logic             reg_allowin;
  logic             s0_valid;
  logic [REG_W-1:0] s0_rd;
  logic [REG_W-1:0] s0_rj;
  logic [REG_W-1:0] s0_rk;
  logic             s0_long;
  logic             s0_div;
  logic             s1_valid;
  logic [REG_W-1:0] s1_rd;
  logic [REG_W-1:0] s1_rj;
  logic [REG_W-1:0] s1_rk;
  logic             s1_long;
  logic             s1_div;
  logic             issue_ok0;
  logic             issue_ok1;
  logic             fire0;
  logic             fire1;

  modport master (
    output reg_allowin,
    output s0_valid, s0_rd, s0_rj, s0_rk, s0_long, s0_div,
    output s1_valid, s1_rd, s1_rj, s1_rk, s1_long, s1_div,
    input  issue_ok0, issue_ok1, fire0, fire1
  );

  modport slave (
    input  reg_allowin,
    input  s0_valid, s0_rd, s0_rj, s0_rk, s0_long, s0_div,
    input  s1_valid, s1_rd, s1_rj, s1_rk, s1_long, s1_div,
    output issue_ok0, issue_ok1, fire0, fire1
  );

endinterface

// File: rtl/issue_scoreboard_sb_counter.sv
// Per-register pending-writer counter: up to two increments and two decrements
// per cycle, applied as one net change. Decrements below zero saturate at zero
// (stale writebacks after a flush); clr has priority over everything.
//   clk, rstn : clock, asynchronous active-low reset
//   clr       : synchronous clear
//   inc, dec  : one bit per issue slot / writeback port
//   cnt       : registered count
module issue_scoreboard_sb_counter #(
  parameter int unsigned CNT_W = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic [1:0]       inc,
  input  logic [1:0]       dec,
  output logic [CNT_W-1:0] cnt
);

  // Two spare bits hold the pre-saturation sum without wrapping.
  localparam int unsigned W = CNT_W + 2;
  localparam logic [W-1:0] CntMax = W'(2 ** CNT_W - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     up, dn, net;
  logic             ovf;

  always_comb begin
    up    = W'(cnt_q) + W'(inc[0]) + W'(inc[1]);
    dn    = W'(dec[0]) + W'(dec[1]);
    net   = (up >= dn) ? (up - dn) : '0;
    ovf   = !clr && (net > CntMax);
    cnt_d = clr ? '0 : net[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

  // The issue gate must never let a counter exceed its maximum.
  overflow_check: assert property (@(posedge clk) disable iff (!rstn) !ovf);

endmodule

// File: rtl/issue_scoreboard.sv
// Register scoreboard and issue gate between the dual-issue queue and register read.
// Tracks in-flight long-latency writers per register, grants slot0/slot1 in order,
// and keeps the divider single-occupancy.
//   clk, rstn          : clock, asynchronous active-low reset
//   flush              : clears all tracking state (synchronous, highest priority)
//   iss                : issue handshake (slave side)
//   wb0_*/wb1_*        : long-latency writeback ports
//   div_busy           : divider occupied
//   sb_empty           : no pending long-latency writes
module issue_scoreboard
  import issue_scoreboard_pkg::*;
#(
  parameter int unsigned NREG    = NREG_DEFAULT,
  parameter int unsigned CNT_W   = CNT_W_DEFAULT,
  parameter int unsigned DIV_LAT = DIV_LAT_DEFAULT
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  issue_scoreboard_if.slave iss,
  input  logic             wb0_valid,
  input  logic [REG_W-1:0] wb0_rd,
  input  logic             wb1_valid,
  input  logic [REG_W-1:0] wb1_rd,
  output logic             div_busy,
  output logic             sb_empty
);

  localparam int unsigned DIV_W = $clog2(DIV_LAT + 1);
  localparam logic [CNT_W-1:0] CntMax   = CNT_W'(2 ** CNT_W - 1);
  localparam logic [CNT_W-1:0] CntMaxM1 = CNT_W'(2 ** CNT_W - 2);

  logic [CNT_W-1:0] cnt [NREG];
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             ok0, ok1, fire0, fire1, div_fire;
  logic [CNT_W-1:0] c0_rd, c0_rj, c0_rk, c1_rd, c1_rj, c1_rk;

  function automatic logic pend(input logic [REG_W-1:0] r, input logic [CNT_W-1:0] c);
    return (r != REG_ZERO) && (c != '0);
  endfunction

  // r0 is never tracked.
  assign cnt[0] = '0;

  for (genvar r = 1; r < NREG; r++) begin : g_cnt
    logic [1:0] inc, dec;
    assign inc = {fire1 && iss.s1_long && (iss.s1_rd == REG_W'(r)),
                  fire0 && iss.s0_long && (iss.s0_rd == REG_W'(r))};
    assign dec = {wb1_valid && (wb1_rd == REG_W'(r)),
                  wb0_valid && (wb0_rd == REG_W'(r))};
    issue_scoreboard_sb_counter #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk  (clk),
      .rstn (rstn),
      .clr  (flush),
      .inc  (inc),
      .dec  (dec),
      .cnt  (cnt[r])
    );
  end

  assign c0_rd = cnt[iss.s0_rd];
  assign c0_rj = cnt[iss.s0_rj];
  assign c0_rk = cnt[iss.s0_rk];
  assign c1_rd = cnt[iss.s1_rd];
  assign c1_rj = cnt[iss.s1_rj];
  assign c1_rk = cnt[iss.s1_rk];

  assign div_busy = (div_cnt_q != '0);

  always_comb begin
    ok0 = iss.s0_valid && !flush
          && !pend(iss.s0_rj, c0_rj) && !pend(iss.s0_rk, c0_rk) && !pend(iss.s0_rd, c0_rd)
          && !(iss.s0_long && (c0_rd == CntMax))
          && !(iss.s0_div && div_busy);

    ok1 = ok0 && iss.s1_valid
          && !pend(iss.s1_rj, c1_rj) && !pend(iss.s1_rk, c1_rk) && !pend(iss.s1_rd, c1_rd)
          && !(iss.s1_long && (c1_rd == CntMax))
          && !(iss.s1_div && div_busy)
          // slot1 must not consume or overwrite slot0's long-latency result
          && !(iss.s0_long && (iss.s0_rd != REG_ZERO)
               && ((iss.s0_rd == iss.s1_rj) || (iss.s0_rd == iss.s1_rk)
                   || (iss.s0_rd == iss.s1_rd)))
          && !(iss.s0_div && iss.s1_div)
          // two increments to one counter need two free steps
          && !(iss.s0_long && iss.s1_long && (iss.s0_rd == iss.s1_rd)
               && (iss.s0_rd != REG_ZERO) && (c0_rd >= CntMaxM1));

    fire0    = ok0 && iss.reg_allowin;
    fire1    = ok1 && iss.reg_allowin;
    div_fire = (fire0 && iss.s0_div) || (fire1 && iss.s1_div);
  end

  assign iss.issue_ok0 = ok0;
  assign iss.issue_ok1 = ok1;
  assign iss.fire0     = fire0;
  assign iss.fire1     = fire1;

  always_comb begin
    div_cnt_d = div_cnt_q;
    if (flush) begin
      div_cnt_d = '0;
    end else if (div_fire) begin
      div_cnt_d = DIV_W'(DIV_LAT);
    end else if (div_cnt_q != '0) begin
      div_cnt_d = div_cnt_q - DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

  always_comb begin
    sb_empty = 1'b1;
    for (int r = 1; r < NREG; r++) begin
      if (cnt[r] != '0) begin
        sb_empty = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_issue_scoreboard.sv
module tb_issue_scoreboard;
  import issue_scoreboard_pkg::*;

  logic             clk = 1'b0;
  logic             rstn = 1'b1;
  logic             flush;
  logic             wb0_valid, wb1_valid;
  logic [REG_W-1:0] wb0_rd, wb1_rd;
  logic             div_busy, sb_empty;

  int n_cmp = 0;
  int n_bad = 0;

  issue_scoreboard_if iss ();

  issue_scoreboard dut (
    .clk       (clk),
    .rstn      (rstn),
    .flush     (flush),
    .iss       (iss),
    .wb0_valid (wb0_valid),
    .wb0_rd    (wb0_rd),
    .wb1_valid (wb1_valid),
    .wb1_rd    (wb1_rd),
    .div_busy  (div_busy),
    .sb_empty  (sb_empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_s0(input logic v, input logic [4:0] rd, input logic [4:0] rj,
                        input logic [4:0] rk, input logic lng, input logic dv);
    iss.s0_valid = v; iss.s0_rd = rd; iss.s0_rj = rj; iss.s0_rk = rk;
    iss.s0_long = lng; iss.s0_div = dv;
  endtask

  task automatic set_s1(input logic v, input logic [4:0] rd, input logic [4:0] rj,
                        input logic [4:0] rk, input logic lng, input logic dv);
    iss.s1_valid = v; iss.s1_rd = rd; iss.s1_rj = rj; iss.s1_rk = rk;
    iss.s1_long = lng; iss.s1_div = dv;
  endtask

  task automatic wb(input logic v0, input logic [4:0] r0, input logic v1, input logic [4:0] r1);
    wb0_valid = v0; wb0_rd = r0; wb1_valid = v1; wb1_rd = r1;
  endtask

  task automatic idle();
    set_s0(0, 0, 0, 0, 0, 0);
    set_s1(0, 0, 0, 0, 0, 0);
    wb(0, 0, 0, 0);
  endtask

  initial begin
    flush = 1'b0;
    iss.reg_allowin = 1'b1;
    idle();

    // Reset state
    #2 rstn = 1'b0;
    #1;
    chk("rst_sb_empty", 8'(sb_empty), 8'd1);
    chk("rst_div_busy", 8'(div_busy), 8'd0);
    chk("rst_ok0", 8'(iss.issue_ok0), 8'd0);
    chk("rst_fire0", 8'(iss.fire0), 8'd0);
    chk("rst_ok1", 8'(iss.issue_ok1), 8'd0);
    step();
    step();
    rstn = 1'b1;

    // Load r5, then a dependent add waits for the writeback
    set_s0(1, 5, 1, 2, 1, 0);
    #1;
    chk("ld5_ok0", 8'(iss.issue_ok0), 8'd1);
    chk("ld5_fire0", 8'(iss.fire0), 8'd1);
    chk("ld5_fire1", 8'(iss.fire1), 8'd0);
    step();
    chk("ld5_cnt5", 8'(dut.cnt[5]), 8'd1);
    chk("ld5_sb_empty", 8'(sb_empty), 8'd0);
    set_s0(1, 6, 5, 0, 0, 0);
    #1;
    chk("raw5_ok0_a", 8'(iss.issue_ok0), 8'd0);
    chk("raw5_fire0", 8'(iss.fire0), 8'd0);
    step();
    wb(1, 5, 0, 0);
    #1;
    chk("raw5_no_bypass", 8'(iss.issue_ok0), 8'd0);
    step();
    wb(0, 0, 0, 0);
    #1;
    chk("raw5_ok0_after_wb", 8'(iss.issue_ok0), 8'd1);
    chk("raw5_sb_empty", 8'(sb_empty), 8'd1);
    step();

    // Slot1 reads slot0's load destination in the same pair
    set_s0(1, 7, 1, 2, 1, 0);
    set_s1(1, 8, 7, 3, 0, 0);
    #1;
    chk("pair7_fire0", 8'(iss.fire0), 8'd1);
    chk("pair7_fire1", 8'(iss.fire1), 8'd0);
    step();
    set_s0(1, 8, 7, 3, 0, 0);
    set_s1(0, 0, 0, 0, 0, 0);
    #1;
    chk("pair7_slot0_held", 8'(iss.issue_ok0), 8'd0);
    wb(0, 0, 1, 7);
    step();
    wb(0, 0, 0, 0);
    #1;
    chk("pair7_slot0_fire", 8'(iss.fire0), 8'd1);
    step();

    // Independent dual issue, with and without reg_allowin
    set_s0(1, 1, 2, 3, 0, 0);
    set_s1(1, 4, 5, 6, 0, 0);
    iss.reg_allowin = 1'b0;
    #1;
    chk("dual_ok1_noallow", 8'(iss.issue_ok1), 8'd1);
    chk("dual_fire0_noallow", 8'(iss.fire0), 8'd0);
    chk("dual_fire1_noallow", 8'(iss.fire1), 8'd0);
    iss.reg_allowin = 1'b1;
    #1;
    chk("dual_fire0", 8'(iss.fire0), 8'd1);
    chk("dual_fire1", 8'(iss.fire1), 8'd1);
    step();

    // Long writers to r0 are ignored
    set_s0(1, 0, 0, 0, 1, 0);
    set_s1(1, 0, 0, 0, 1, 0);
    #1;
    chk("r0_fire0", 8'(iss.fire0), 8'd1);
    chk("r0_fire1", 8'(iss.fire1), 8'd1);
    step();
    idle();
    #1;
    chk("r0_sb_empty", 8'(sb_empty), 8'd1);

    // Two long writers, then both writeback ports hit r3 (saturates at zero)
    set_s0(1, 3, 1, 2, 1, 0);
    set_s1(1, 4, 1, 2, 1, 0);
    #1;
    chk("ld34_fire1", 8'(iss.fire1), 8'd1);
    step();
    idle();
    wb(1, 3, 1, 3);
    step();
    wb(0, 0, 0, 0);
    #1;
    chk("wb33_cnt3", 8'(dut.cnt[3]), 8'd0);
    chk("wb33_cnt4", 8'(dut.cnt[4]), 8'd1);
    chk("wb33_sb_empty", 8'(sb_empty), 8'd0);
    wb(0, 0, 1, 4);
    step();
    wb(0, 0, 0, 0);
    #1;
    chk("wb4_sb_empty", 8'(sb_empty), 8'd1);

    // WAW inside a pair blocks slot1
    set_s0(1, 13, 1, 2, 1, 0);
    set_s1(1, 13, 1, 2, 1, 0);
    #1;
    chk("waw13_fire0", 8'(iss.fire0), 8'd1);
    chk("waw13_fire1", 8'(iss.fire1), 8'd0);
    step();
    chk("waw13_cnt13", 8'(dut.cnt[13]), 8'd1);
    // Increment and stale writeback on r12 cancel; r13 drains
    set_s0(1, 12, 0, 0, 1, 0);
    set_s1(0, 0, 0, 0, 0, 0);
    wb(1, 12, 1, 13);
    #1;
    chk("cancel12_fire0", 8'(iss.fire0), 8'd1);
    step();
    idle();
    #1;
    chk("cancel12_cnt12", 8'(dut.cnt[12]), 8'd0);
    chk("cancel12_sb_empty", 8'(sb_empty), 8'd1);

    // Divider occupancy
    set_s0(1, 10, 1, 2, 0, 1);
    #1;
    chk("div_fire0", 8'(iss.fire0), 8'd1);
    chk("div_busy_pre", 8'(div_busy), 8'd0);
    step();
    set_s0(1, 11, 1, 2, 0, 1);
    set_s1(1, 15, 1, 2, 0, 1);
    for (int i = 1; i <= 17; i++) begin
      #1;
      chk($sformatf("div_busy_c%0d", i), 8'(div_busy), 8'd1);
      chk($sformatf("div_held_c%0d", i), 8'(iss.issue_ok0), 8'd0);
      step();
    end
    #1;
    chk("div_busy_c18", 8'(div_busy), 8'd0);
    chk("div2_fire0_c18", 8'(iss.fire0), 8'd1);
    chk("div2_fire1_c18", 8'(iss.fire1), 8'd0);
    step();

    // Flush with cnt[9]=1 and divider busy
    set_s0(1, 9, 1, 2, 1, 0);
    set_s1(0, 0, 0, 0, 0, 0);
    #1;
    chk("ld9_fire0", 8'(iss.fire0), 8'd1);
    step();
    set_s0(1, 20, 1, 2, 0, 0);
    flush = 1'b1;
    #1;
    chk("flush_ok0", 8'(iss.issue_ok0), 8'd0);
    chk("flush_div_busy_pre", 8'(div_busy), 8'd1);
    chk("flush_cnt9_pre", 8'(dut.cnt[9]), 8'd1);
    step();
    flush = 1'b0;
    idle();
    #1;
    chk("flush_sb_empty", 8'(sb_empty), 8'd1);
    chk("flush_div_busy", 8'(div_busy), 8'd0);
    chk("flush_cnt9", 8'(dut.cnt[9]), 8'd0);
    wb(1, 9, 0, 0);
    step();
    wb(0, 0, 0, 0);
    #1;
    chk("stale_wb9_cnt9", 8'(dut.cnt[9]), 8'd0);
    chk("stale_wb9_sb_empty", 8'(sb_empty), 8'd1);

    // Asynchronous reset mid-operation
    set_s0(1, 9, 1, 2, 1, 0);
    step();
    idle();
    #1;
    chk("pre_rst_sb_empty", 8'(sb_empty), 8'd0);
    #2 rstn = 1'b0;
    #1;
    chk("async_rst_sb_empty", 8'(sb_empty), 8'd1);
    chk("async_rst_cnt9", 8'(dut.cnt[9]), 8'd0);
    step();
    rstn = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/issue_scoreboard.md
Name: issue_scoreboard

Overview:
- Register scoreboard and issue gate sitting between the dual-issue queue output and the register-read stage.
- Tracks in-flight long-latency writers (load, mul, div) per architectural register.
- Grants slot0/slot1 issue only when their sources and destinations are free of pending long-latency writes.
- Enforces in-order issue and the single-occupancy divider.

Parameters:
- NREG, 32, number of architectural registers; r0 is never tracked.
- CNT_W, 2, width of each per-register pending counter; the maximum count is 2^CNT_W-1.
- DIV_LAT, 17, cycles from divider issue until the divider accepts a new op.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- flush  in  1  pipeline flush; clears all tracking state
- reg_allowin  in  1  register-read stage can accept this cycle
- s0_valid  in  1  slot0 holds a valid instruction
- s0_rd/s0_rj/s0_rk  in  5 each  slot0 register indices
- s0_long  in  1  slot0 writes rd with long latency
- s0_div  in  1  slot0 is a divide
- s1_valid, s1_rd, s1_rj, s1_rk, s1_long, s1_div  in  1/5/5/5/1/1  same fields for slot1
- wb0_valid, wb0_rd  in  1/5  long-latency writeback port 0
- wb1_valid, wb1_rd  in  1/5  long-latency writeback port 1
- issue_ok0  out  1  slot0 may issue
- issue_ok1  out  1  slot1 may issue
- fire0, fire1  out  1 each  slot issued this cycle
- div_busy  out  1  divider occupied
- sb_empty  out  1  no pending long-latency writes

Behaviour:
- Rule: a register index of 0 never blocks, never increments and never decrements.
- State: cnt[1..NREG-1] of CNT_W bits; div_cnt of clog2(DIV_LAT+1) bits. All zero on reset (asynchronous) and on flush (synchronous; flush has priority over all updates).
- hazard(r) = (r!=0) && cnt[r]!=0. Hazards use registered cnt only; same-cycle writeback does not bypass.
- issue_ok0 = s0_valid && !hazard(s0_rj) && !hazard(s0_rk) && !hazard(s0_rd) && !(s0_long && cnt[s0_rd]==max) && !(s0_div && div_busy) && !flush.
  - The s0_rd term blocks WAW.
- issue_ok1 = issue_ok0 && s1_valid, plus the same checks on slot1's fields, and:
  - Not if s0_long && s0_rd!=0 && s0_rd in {s1_rj, s1_rk, s1_rd}.
  - Not if s0_div && s1_div.
  - Not if s0_long && s1_long && s0_rd==s1_rd && cnt>=max-1.
- fire0 = issue_ok0 && reg_allowin. fire1 = issue_ok1 && reg_allowin. Slot1 never fires without slot0 (in-order).
- Counter update per cycle, net applied:
  - cnt[r] += (fire0&&s0_long&&s0_rd==r) + (fire1&&s1_long&&s1_rd==r).
  - cnt[r] -= (wb0_valid&&wb0_rd==r) + (wb1_valid&&wb1_rd==r).
  - Increment and decrement on the same register in one cycle cancel.
- Underflow: a decrement reaching a zero counter saturates at 0 (stale writeback after flush); no error flag.
- Overflow is impossible by the issue_ok gating; assert in simulation.
- Divider:
  - div_busy = div_cnt!=0.
  - A div fire loads div_cnt = DIV_LAT.
  - Otherwise div_cnt decrements while nonzero.
  - Flush clears div_cnt.
- sb_empty = all cnt zero (combinational).
- Latency: issue_ok0/1 are combinational in the current inputs and registered state. Counter updates are visible the next cycle.
- Reset values: all counters 0, div_busy 0, sb_empty 1, issue_ok/fire 0 while inputs are invalid.
- Reset mid-operation: rstn low clears state immediately; outputs follow combinationally.

Decomposition:
- Shared package: NREG, CNT_W, DIV_LAT defaults, and a REG_ZERO constant.
- One natural sub-module, sb_counter: a single saturating up/down counter with inc[1:0], dec[1:0] and clr, instantiated NREG-1 times via generate.
- Hazard and grant logic stay in the top.

Test Plan:
- Load r5 in slot0 (s0_long, reg_allowin=1) -> next cycle cnt[5]=1; an add reading r5 gets issue_ok0=0 until wb0_valid rd=5, then issue_ok0=1 the following cycle.
- Slot0 load r7, slot1 add rj=7, same cycle -> fire0=1, fire1=0; the next pair issues slot1's instruction as slot0.
- Divide fires -> div_busy=1 for exactly 17 cycles; a second divide is held the whole time and fires on cycle 18.
- Writebacks on wb0 and wb1 to r3 in the same cycle, with cnt[3]=2 -> cnt[3]=0, sb_empty=1 next cycle.
- Flush with cnt[9]=1 and div_busy=1 -> all clear the next cycle; a later wb to r9 leaves cnt[9]=0 (no underflow).
- Both slots long with rd=0 -> both fire, no counter changes, sb_empty stays 1.
